ex_operand_stage: RTL

//  Registered decode/operand-select stage directly upstream of the RV32I ALU. Takes one

---
 rtl/ex_operand_stage.sv | 320 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// -----------------------------------------------------------------------------
// ex_operand_stage
//
// Registered decode / operand-select stage feeding the RV32I ALU. One
// instruction plus its register-file read data is decoded, writeback
// forwarding is applied to the source operands, and the resulting ALU
// operands, function code and writeback control are held in a single
// valid/ready pipeline register. Supports downstream stall and flush.
//
// Parameters
//   FWD_EN    1: a matching writeback (fwd_we, fwd_rd == rs != 0) replaces the
//                register-file read data at capture; 0: no forwarding
//   ILL_TRAP  1: illegal instructions are presented with out_illegal=1
//             0: illegal instructions are consumed and never presented
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   flush               kill the held entry and the entry offered this cycle
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_instr, in_pc     raw instruction and its PC
//   in_rs1_data/rs2     register-file reads of instr[19:15] / instr[24:20]
//   fwd_we/rd/data      writeback port used for forwarding
//   out_valid/out_ready downstream handshake
//   out_op1/op2/alu_sel ALU operands and function code
//   out_rd, out_rd_we   destination register (0 when none) and write enable
//   out_is_br           conditional branch, out_funct3 selects the condition
//   out_funct3          instr[14:12]
//   out_illegal         unsupported opcode or funct encoding
// -----------------------------------------------------------------------------
module ex_operand_stage #(
    parameter bit FWD_EN   = 1'b1,
    parameter bit ILL_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic        fwd_we,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [3:0]  out_alu_sel,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_is_br,
    output logic [2:0]  out_funct3,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] SEL_ADD  = 4'h0;
    localparam logic [3:0] SEL_SUB  = 4'h1;
    localparam logic [3:0] SEL_PASS = 4'h2;
    localparam logic [3:0] SEL_SLL  = 4'h3;
    localparam logic [3:0] SEL_SRL  = 4'h4;
    localparam logic [3:0] SEL_SRA  = 4'h5;
    localparam logic [3:0] SEL_XOR  = 4'h6;
    localparam logic [3:0] SEL_OR   = 4'h7;
    localparam logic [3:0] SEL_AND  = 4'h8;
    localparam logic [3:0] SEL_SLT  = 4'h9;
    localparam logic [3:0] SEL_SLTU = 4'hA;

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_idx;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt_ext;

    assign opcode    = in_instr[6:0];
    assign rd_idx    = in_instr[11:7];
    assign funct3    = in_instr[14:12];
    assign rs1_idx   = in_instr[19:15];
    assign rs2_idx   = in_instr[24:20];
    assign funct7    = in_instr[31:25];
    assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u     = {in_instr[31:12], 12'b0};
    assign shamt_ext = {27'b0, in_instr[24:20]};

    // ------------------------------------------------------------------
    // Source operands: x0 is hard zero, then writeback forwarding
    // ------------------------------------------------------------------
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    always_comb begin
        rs1_val = in_rs1_data;
        if (rs1_idx == 5'd0) begin
            rs1_val = 32'd0;
        end else if (FWD_EN && fwd_we && (fwd_rd == rs1_idx)) begin
            rs1_val = fwd_data;
        end
    end

    always_comb begin
        rs2_val = in_rs2_data;
        if (rs2_idx == 5'd0) begin
            rs2_val = 32'd0;
        end else if (FWD_EN && fwd_we && (fwd_rd == rs2_idx)) begin
            rs2_val = fwd_data;
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [31:0] dec_op1;
    logic [31:0] dec_op2;
    logic [3:0]  dec_sel;
    logic        dec_writes;
    logic        dec_is_br;
    logic        dec_ill;
    logic [4:0]  dec_rd;
    logic        dec_rd_we;

    always_comb begin
        dec_op1    = 32'd0;
        dec_op2    = 32'd0;
        dec_sel    = SEL_ADD;
        dec_writes = 1'b0;
        dec_is_br  = 1'b0;
        dec_ill    = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_op1    = rs1_val;
                dec_op2    = rs2_val;
                dec_writes = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     dec_sel = SEL_ADD;
                        else if (funct7 == F7_ALT) dec_sel = SEL_SUB;
                        else                       dec_ill = 1'b1;
                    end
                    3'b001: begin
                        dec_sel = SEL_SLL;
                        dec_op2 = {27'b0, rs2_val[4:0]};
                        dec_ill = (funct7 != F7_BASE);
                    end
                    3'b010: begin
                        dec_sel = SEL_SLT;
                        dec_ill = (funct7 != F7_BASE);
                    end
                    3'b011: begin
                        dec_sel = SEL_SLTU;
                        dec_ill = (funct7 != F7_BASE);
                    end
                    3'b100: begin
                        dec_sel = SEL_XOR;
                        dec_ill = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        dec_op2 = {27'b0, rs2_val[4:0]};
                        if (funct7 == F7_BASE)     dec_sel = SEL_SRL;
                        else if (funct7 == F7_ALT) dec_sel = SEL_SRA;
                        else                       dec_ill = 1'b1;
                    end
                    3'b110: begin
                        dec_sel = SEL_OR;
                        dec_ill = (funct7 != F7_BASE);
                    end
                    default: begin
                        dec_sel = SEL_AND;
                        dec_ill = (funct7 != F7_BASE);
                    end
                endcase
            end

            OPC_OP_IMM: begin
                dec_op1    = rs1_val;
                dec_op2    = imm_i;
                dec_writes = 1'b1;
                case (funct3)
                    3'b000: dec_sel = SEL_ADD;
                    3'b010: dec_sel = SEL_SLT;
                    3'b011: dec_sel = SEL_SLTU;
                    3'b100: dec_sel = SEL_XOR;
                    3'b110: dec_sel = SEL_OR;
                    3'b111: dec_sel = SEL_AND;
                    3'b001: begin
                        dec_sel = SEL_SLL;
                        dec_op2 = shamt_ext;
                        dec_ill = (funct7 != F7_BASE);
                    end
                    default: begin
                        dec_op2 = shamt_ext;
                        if (funct7 == F7_BASE)     dec_sel = SEL_SRL;
                        else if (funct7 == F7_ALT) dec_sel = SEL_SRA;
                        else                       dec_ill = 1'b1;
                    end
                endcase
            end

            OPC_LUI: begin
                dec_op2    = imm_u;
                dec_sel    = SEL_PASS;
                dec_writes = 1'b1;
            end

            OPC_AUIPC: begin
                dec_op1    = in_pc;
                dec_op2    = imm_u;
                dec_writes = 1'b1;
            end

            // Link value pc+4; the target is computed elsewhere.
            OPC_JAL, OPC_JALR: begin
                dec_op1    = in_pc;
                dec_op2    = 32'd4;
                dec_writes = 1'b1;
            end

            OPC_LOAD: begin
                dec_op1    = rs1_val;
                dec_op2    = imm_i;
                dec_writes = 1'b1;
            end

            OPC_STORE: begin
                dec_op1 = rs1_val;
                dec_op2 = imm_s;
            end

            OPC_BRANCH: begin
                dec_op1   = rs1_val;
                dec_op2   = rs2_val;
                dec_sel   = SEL_SUB;
                dec_is_br = 1'b1;
                dec_ill   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end

            default: begin
                dec_ill = 1'b1;
            end
        endcase

        // Illegal encodings carry no operands and no side effects.
        if (dec_ill) begin
            dec_op1    = 32'd0;
            dec_op2    = 32'd0;
            dec_sel    = SEL_ADD;
            dec_writes = 1'b0;
            dec_is_br  = 1'b0;
        end
    end

    // A write to x0 is no write at all.
    assign dec_rd_we = dec_writes && (rd_idx != 5'd0);
    assign dec_rd    = dec_rd_we ? rd_idx : 5'd0;

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic capture;
    logic present;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign present  = !dec_ill || ILL_TRAP;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_op1     <= 32'd0;
            out_op2     <= 32'd0;
            out_alu_sel <= 4'd0;
            out_rd      <= 5'd0;
            out_rd_we   <= 1'b0;
            out_is_br   <= 1'b0;
            out_funct3  <= 3'd0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            // A suppressed illegal instruction still consumes the slot.
            out_valid <= present;
            if (present) begin
                out_op1     <= dec_op1;
                out_op2     <= dec_op2;
                out_alu_sel <= dec_sel;
                out_rd      <= dec_rd;
                out_rd_we   <= dec_rd_we;
                out_is_br   <= dec_is_br;
                out_funct3  <= funct3;
                out_illegal <= dec_ill;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
